// File: rtl/sng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sng_pkg
// Description : Shared types and LFSR tap table for the stochastic number
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci feedback masks, bit n-1 set for polynomial term x^n.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0829;
            13:      lfsr_taps = 16'h100D;
            14:      lfsr_taps = 16'h2015;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sng_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : sng_lfsr
// Description : Maximal-length Fibonacci LFSR, period 2^WIDTH-1, with reload.
// Revision    : 1.0 - initial release
// ============================================================================
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    localparam logic [15:0]      c_TAPS16 = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] c_TAPS   = c_TAPS16[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & c_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/sng_stream.sv
`default_nettype none
// ============================================================================
// Module      : sng_stream
// Description : Converts a latched operand into a 2^WIDTH-bit unipolar stream
//               whose popcount equals the operand (counter or LFSR source).
// Revision    : 1.0 - initial release
// ============================================================================
module sng_stream
    import sng_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] value,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [15:0]      c_TAPS16 = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] c_TAPS   = c_TAPS16[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_LAST   = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             mode_q, mode_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] w_lfsr;
    logic [WIDTH-1:0] w_lfsr_nx;
    logic [WIDTH-1:0] w_idx_nx;
    logic [WIDTH-1:0] w_src0;
    logic [WIDTH-1:0] w_src_nx;
    logic             w_accept;
    logic             w_run;

    assign w_run    = (state_q == RUN);
    assign w_accept = start && !w_run;

    sng_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .en   (w_run),
        .q    (w_lfsr)
    );

    // Outputs are registered, so each edge computes the bit for the following
    // index: the LFSR successor is evaluated here one step ahead of u_lfsr.
    assign w_lfsr_nx = {w_lfsr[WIDTH-2:0], ^(w_lfsr & c_TAPS)};
    assign w_idx_nx  = idx_q + 1'b1;
    assign w_src0    = mode ? (SEED - 1'b1) : '0;
    assign w_src_nx  = !mode_q              ? w_idx_nx :
                       (w_idx_nx == c_LAST) ? c_LAST   :
                                              (w_lfsr_nx - 1'b1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        mode_d  = mode_q;
        bit_d   = 1'b0;
        case (state_q)
            RUN: begin
                idx_d = w_idx_nx;
                if (idx_q == c_LAST) begin
                    state_d = DONE;
                end else begin
                    bit_d = (w_src_nx < val_q);
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    val_d   = value;
                    mode_d  = mode;
                    bit_d   = (w_src0 < value);
                end
            end
        endcase
        valid_d = (state_d == RUN);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            val_q   <= '0;
            mode_q  <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sng_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sng_stream
// Description : Scoreboard bench for sng_stream (WIDTH=8, SEED=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sng_stream;

    typedef struct packed {
        logic       b;
        logic       last;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] value;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       done;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    sng_stream #(
        .WIDTH (8),
        .SEED  (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .value     (value),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stream from an independent model; hand-derived first bits for
    // value 0x80 in LFSR mode (states 01,02,04,08,11,23,47,8E) when use_gold.
    function automatic void push_stream(input logic [7:0] v, input logic m, input bit use_gold);
        logic [7:0] s;
        logic [7:0] src;
        logic [7:0] gold;
        exp_t       e;
        s    = 8'h01;
        gold = 8'h7F;
        for (int i = 0; i < 256; i++) begin
            if (!m)            src = 8'(i);
            else if (i == 255) src = 8'hFF;
            else               src = s - 8'd1;
            e.b = (src < v);
            if (use_gold && i < 8) e.b = gold[i];
            e.last = (i == 255);
            e.val  = v;
            exp_q.push_back(e);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    endfunction

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_vec++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL wait_done: done pulses %0d, required %0d", done_cnt, target);
        end
    endtask

    task automatic issue(input logic [7:0] v, input logic m);
        start = 1'b1;
        value = v;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] v, input logic m, input bit use_gold);
        int t;
        t = done_cnt + 1;
        push_stream(v, m, use_gold);
        issue(v, m);
        wait_done(t);
    endtask

    task automatic chk_valid(input logic req, input string name);
        n_vec++;
        if (bit_valid !== req) begin
            n_fail++;
            $display("FAIL %s: bit_valid=%0b, required %0b", name, bit_valid, req);
        end
    endtask

    // Monitor: pops one expectation per valid bit, checks done/busy framing.
    initial begin : monitor
        exp_t e;
        logic prev_last;
        int   ones;
        int   bi;
        prev_last = 1'b0;
        ones      = 0;
        bi        = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_last = 1'b0;
                ones      = 0;
                bi        = 0;
            end else begin
                n_vec++;
                if (done !== prev_last) begin
                    n_fail++;
                    $display("FAIL done: got %0b, expected %0b", done, prev_last);
                end
                if (done === 1'b1) done_cnt++;
                n_vec++;
                if (busy !== bit_valid) begin
                    n_fail++;
                    $display("FAIL busy: got %0b, expected %0b", busy, bit_valid);
                end
                prev_last = 1'b0;
                if (bit_valid === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_bit: bit_valid=1 with no expected bit");
                    end else begin
                        e = exp_q.pop_front();
                        if (bit_out !== e.b) begin
                            n_fail++;
                            $display("FAIL bit[%0d] val=%02h: got %0b, expected %0b", bi, e.val, bit_out, e.b);
                        end
                        if (bit_out === 1'b1) ones++;
                        bi++;
                        prev_last = e.last;
                        if (e.last) begin
                            n_vec++;
                            if (ones != int'(e.val)) begin
                                n_fail++;
                                $display("FAIL popcount: got %0d, expected %0d", ones, e.val);
                            end
                            ones = 0;
                            bi   = 0;
                        end
                    end
                end else begin
                    n_vec++;
                    if (bit_out !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bit_out_idle: got %0b, expected 0", bit_out);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        value = 8'h00;
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %04b, expected 0000", {bit_out, bit_valid, busy, done});
        end
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b1;
        @(negedge clk);

        run(8'h40, 1'b0, 1'b0);
        run(8'h00, 1'b0, 1'b0);
        run(8'h00, 1'b1, 1'b0);
        run(8'hFF, 1'b0, 1'b0);
        run(8'hFF, 1'b1, 1'b0);
        run(8'h80, 1'b1, 1'b1);
        run(8'h80, 1'b1, 1'b1);

        // start pulses during RUN carry a different operand and must be ignored
        t = done_cnt + 1;
        push_stream(8'h5A, 1'b1, 1'b0);
        issue(8'h5A, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; value = 8'hFF; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (89) @(negedge clk);
        start = 1'b1; value = 8'h01; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(t);

        // asynchronous reset in the middle of a stream
        push_stream(8'h33, 1'b1, 1'b0);
        issue(8'h33, 1'b1);
        repeat (50) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_midstream: got %04b, expected 0000", {bit_out, bit_valid, busy, done});
        end
        exp_q.delete();
        @(negedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        run(8'h10, 1'b1, 1'b0);

        // start held high: streams repeat with a single idle DONE cycle between
        t = done_cnt;
        push_stream(8'hC3, 1'b1, 1'b0);
        push_stream(8'hC3, 1'b1, 1'b0);
        push_stream(8'hC3, 1'b1, 1'b0);
        start = 1'b1; value = 8'hC3; mode = 1'b1;
        wait_done(t + 1);
        chk_valid(1'b0, "gap1_done_cycle");
        @(negedge clk); #1;
        chk_valid(1'b1, "gap1_restart");
        wait_done(t + 2);
        chk_valid(1'b0, "gap2_done_cycle");
        @(negedge clk); #1;
        chk_valid(1'b1, "gap2_restart");
        start = 1'b0;
        wait_done(t + 3);
        chk_valid(1'b0, "gap3_done_cycle");
        @(negedge clk); #1;
        chk_valid(1'b0, "no_restart");

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_bits: %0d expected bits never appeared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sng_stream.md
# sng_stream

Stochastic number generator feeding the toggle/accumulate stages of the CBSC MAC datapath. It converts a latched WIDTH-bit binary operand into a 2^WIDTH-cycle unipolar bitstream. The stream drives the downstream T input one bit per cycle. Over one stream, the number of 1s equals the operand exactly, in both deterministic (counter) and pseudo-random (LFSR) modes.

## Interface
- WIDTH, 8, operand width; stream length is 2^WIDTH cycles (legal 4..16)
- SEED, 1, LFSR reload value; must be nonzero, WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request a new stream; accepted only when busy=0
- mode  input  1  0 = counter/thermometer source, 1 = LFSR source; sampled with start
- value  input  WIDTH  operand; sampled with start
- bit_out  output  1  stream bit, meaningful when bit_valid=1, else 0
- bit_valid  output  1  high for exactly 2^WIDTH consecutive cycles per stream
- busy  output  1  high from accept through the last valid bit
- done  output  1  one-cycle pulse in the cycle after the last valid bit

## Operation
- States: IDLE, RUN, DONE.
  - Reset (rst=0) forces IDLE asynchronously.
  - IDLE -> RUN on start.
  - RUN -> DONE after bit index 2^WIDTH-1.
  - DONE -> RUN if start is high in that cycle, else -> IDLE.
- On accept:
  - latch value into val_q and mode into mode_q;
  - clear idx (WIDTH bits);
  - reload LFSR with SEED.
- In RUN, each cycle: bit_out = (src < val_q), then idx increments.
  - Counter mode: src = idx.
  - LFSR mode: src = lfsr-1 for idx < 2^WIDTH-1; src = 2^WIDTH-1 at the final idx.
  - The LFSR is a maximal-length Fibonacci register of period 2^WIDTH-1 and advances once per RUN cycle.
- Consequence: the popcount per stream equals val_q, with no saturation.
  - value=0 gives all zeros.
  - value=2^WIDTH-1 gives all ones except exactly one 0.
- Comparison is unsigned and WIDTH bits wide; idx wraps to 0 after the final bit and is not used outside RUN.
- start while busy=1 is ignored; value and mode changes during RUN have no effect.
- Reset mid-stream:
  - all outputs are 0 immediately;
  - the stream is abandoned and done is not pulsed;
  - the next start begins a fresh stream from SEED.

## Timing
- Reset values: bit_out=0, bit_valid=0, busy=0, done=0, state=IDLE, idx=0, lfsr=SEED.
- All outputs are registered.
- For start sampled high at edge k:
  - busy and bit_valid are high in cycles k+1 .. k+2^WIDTH;
  - bit i appears in cycle k+1+i;
  - done is high only in cycle k+2^WIDTH+1.
- Back-to-back: start high during the DONE cycle (edge k+2^WIDTH+1) gives the next stream's first bit in cycle k+2^WIDTH+2. The gap is one cycle of bit_valid=0.
- LFSR-mode sequences are identical for identical (SEED, value) across streams.

## Structure
- Shared package sng_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - function lfsr_taps(width), returning maximal-length tap masks for WIDTH 4..16 (WIDTH=8: x^8+x^6+x^5+x^4+1).
- One sub-module, sng_lfsr:
  - parameters WIDTH, SEED;
  - inputs clk, rst, load, en;
  - output q.
- FSM, counter, and comparator stay in sng_stream.

## Test plan
- Counter mode, WIDTH=8, value=0x40 -> 256 valid bits: bits 0..63 =1, 64..255 =0; done pulses one cycle after bit 255.
- value=0x00 and value=0xFF (each mode) -> popcounts 0 and 255; bit_valid exactly 256 cycles, busy drops with done.
- LFSR mode, value=0x80, two consecutive streams -> each has popcount 128; the bit sequences are identical; the first 8 bits match the golden model from SEED=1.
- start re-asserted at RUN cycles 10 and 100 with a different value -> ignored; the stream and popcount stay those of the original value.
- rst pulled low at RUN cycle 50 -> outputs 0 in the same cycle, no done; a new start with value=0x10 gives popcount 16.
- start held high continuously -> streams repeat with exactly one bit_valid=0 gap (the DONE cycle) between them.
